// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: latches an III_XXX_YYY instruction and steps it through T1..T3.
// Optional feature macro: MVNZ_EN (opcode 100 = mvnz, conditional move on !g_zero).
module instr_sequencer #(
    parameter int unsigned OPW  = 3,
    parameter int unsigned REGW = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  run,
    input  logic [OPW+2*REGW-1:0] din,
    input  logic                  g_zero,
    output logic [REGW-1:0]       rx_sel,
    output logic                  reg_write,
    output logic [3:0]            bus_sel,
    output logic                  a_in,
    output logic                  g_in,
    output logic                  add_sub,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned IW = OPW + 2 * REGW;

    localparam logic [OPW-1:0] OpMv   = OPW'(0);
    localparam logic [OPW-1:0] OpMvi  = OPW'(1);
    localparam logic [OPW-1:0] OpAdd  = OPW'(2);
    localparam logic [OPW-1:0] OpSub  = OPW'(3);
`ifdef MVNZ_EN
    localparam logic [OPW-1:0] OpMvnz = OPW'(4);
`endif

    localparam logic [3:0] BusDin  = 4'd8;
    localparam logic [3:0] BusG    = 4'd9;
    localparam logic [3:0] BusNone = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StT1,
        StT2,
        StT3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] reg_x;
    logic [REGW-1:0] reg_y;

    assign opcode = ir_q[IW-1 -: OPW];
    assign reg_x  = ir_q[2*REGW-1 -: REGW];
    assign reg_y  = ir_q[REGW-1:0];

`ifndef MVNZ_EN
    // g_zero only matters for mvnz; keep it visibly consumed in the default build.
    logic unused_g_zero;
    assign unused_g_zero = g_zero;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and IR capture; run/din are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    ir_d    = din;
                    state_d = StT1;
                end
            end
            StT1: begin
                if (opcode == OpAdd || opcode == OpSub) begin
                    state_d = StT2;
                end else begin
                    state_d = StIdle;
                end
            end
            StT2:    state_d = StT3;
            StT3:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from state and IR; g_zero enters only for mvnz in T1.
    always_comb begin
        rx_sel    = reg_x;
        reg_write = 1'b0;
        bus_sel   = BusNone;
        a_in      = 1'b0;
        g_in      = 1'b0;
        add_sub   = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StT1: begin
                case (opcode)
                    OpMv: begin
                        bus_sel   = 4'(reg_y);
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    OpMvi: begin
                        bus_sel   = BusDin;
                        reg_write = 1'b1;
                        done      = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        bus_sel = 4'(reg_x);
                        a_in    = 1'b1;
                    end
`ifdef MVNZ_EN
                    OpMvnz: begin
                        bus_sel   = 4'(reg_y);
                        reg_write = !g_zero;
                        done      = 1'b1;
                    end
`endif
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            StT2: begin
                bus_sel = 4'(reg_y);
                g_in    = 1'b1;
                add_sub = opcode[0];
            end
            StT3: begin
                bus_sel   = BusG;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected output vectors are queued per cycle and
// popped/checked on the falling edge. Honours MVNZ_EN for the opcode-100 cases.
module tb_instr_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       run;
    logic [8:0] din;
    logic       g_zero;
    logic [2:0] rx_sel;
    logic       reg_write;
    logic [3:0] bus_sel;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic       done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] exp_q[$];

    instr_sequencer dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .din       (din),
        .g_zero    (g_zero),
        .rx_sel    (rx_sel),
        .reg_write (reg_write),
        .bus_sel   (bus_sel),
        .a_in      (a_in),
        .g_in      (g_in),
        .add_sub   (add_sub),
        .done      (done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Packed as {busy, done, add_sub, g_in, a_in, reg_write, bus_sel, rx_sel}.
    function automatic logic [12:0] vec(input logic b, input logic d, input logic as,
                                        input logic gi, input logic ai, input logic rw,
                                        input logic [3:0] bs, input logic [2:0] rx);
        return {b, d, as, gi, ai, rw, bs, rx};
    endfunction

    function automatic logic [12:0] idle_v(input logic [2:0] rx);
        return vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, rx);
    endfunction

    task automatic check_now(input string tag);
        logic [12:0] obs;
        logic [12:0] expv;
        obs = {busy, done, add_sub, g_in, a_in, reg_write, bus_sel, rx_sel};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h required queued expectation", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", tag, obs, expv);
            end
        end
    endtask

    // Drive inputs, queue the expected post-edge outputs, clock once, check on the falling edge.
    task automatic cycle(input string tag, input logic r, input logic [8:0] d, input logic gz,
                         input logic [12:0] expv);
        run    = r;
        din    = d;
        g_zero = gz;
        exp_q.push_back(expv);
        @(posedge clock);
        @(negedge clock);
        check_now(tag);
    endtask

    initial begin
        resetn = 1'b0;
        run    = 1'b1;
        din    = 9'o012;
        g_zero = 1'b0;

        // Reset held with run asserted: nothing may be accepted.
        exp_q.push_back(idle_v(3'd0));
        #1 check_now("rst_t0");
        cycle("rst_c1", 1'b1, 9'o012, 1'b0, idle_v(3'd0));
        cycle("rst_c2", 1'b1, 9'o012, 1'b0, idle_v(3'd0));
        cycle("rst_c3", 1'b1, 9'o012, 1'b0, idle_v(3'd0));
        resetn = 1'b1;
        // 012 = mv R1,R2
        cycle("rst_accept", 1'b1, 9'o012, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd2, 3'd1));
        cycle("rst_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd1));

        // mv R3,R5
        cycle("mv_t1", 1'b1, 9'b000_011_101, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd5, 3'd3));
        cycle("mv_idle", 1'b0, 9'b111_111_111, 1'b0, idle_v(3'd3));

        // sub R2,R7
        cycle("sub_t1", 1'b1, 9'b011_010_111, 1'b0, vec(1, 0, 0, 0, 1, 0, 4'd2, 3'd2));
        cycle("sub_t2", 1'b0, 9'o000, 1'b0, vec(1, 0, 1, 1, 0, 0, 4'd7, 3'd2));
        cycle("sub_t3", 1'b0, 9'o000, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd9, 3'd2));
        cycle("sub_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd2));

        // add R1,R4 with run held and din churning while busy, then mvi R6 back to back.
        cycle("add_t1", 1'b1, 9'b010_001_100, 1'b0, vec(1, 0, 0, 0, 1, 0, 4'd1, 3'd1));
        cycle("add_t2", 1'b1, 9'o777, 1'b1, vec(1, 0, 0, 1, 0, 0, 4'd4, 3'd1));
        cycle("add_t3", 1'b1, 9'o123, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd9, 3'd1));
        cycle("add_idle", 1'b1, 9'o456, 1'b0, idle_v(3'd1));
        cycle("mvi_t1", 1'b1, 9'b001_110_000, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd8, 3'd6));
        cycle("mvi_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd6));

        // run held high: mv every 2 cycles.
        cycle("thr_a", 1'b1, 9'b000_000_001, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd1, 3'd0));
        cycle("thr_b", 1'b1, 9'b000_111_011, 1'b0, idle_v(3'd0));
        cycle("thr_c", 1'b1, 9'b000_111_011, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd3, 3'd7));
        cycle("thr_d", 1'b0, 9'o000, 1'b0, idle_v(3'd7));

        // Undefined opcode 101 is a NOP.
        cycle("nop_t1", 1'b1, 9'b101_100_010, 1'b0, vec(1, 1, 0, 0, 0, 0, 4'd15, 3'd4));
        cycle("nop_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd4));

        // Opcode 100 with g_zero high, then low.
`ifdef MVNZ_EN
        cycle("op4_gz1", 1'b1, 9'b100_011_010, 1'b1, vec(1, 1, 0, 0, 0, 0, 4'd2, 3'd3));
        cycle("op4_gz1_idle", 1'b0, 9'o000, 1'b1, idle_v(3'd3));
        cycle("op4_gz0", 1'b1, 9'b100_101_110, 1'b0, vec(1, 1, 0, 0, 0, 1, 4'd6, 3'd5));
        cycle("op4_gz0_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd5));
`else
        cycle("op4_gz1", 1'b1, 9'b100_011_010, 1'b1, vec(1, 1, 0, 0, 0, 0, 4'd15, 3'd3));
        cycle("op4_gz1_idle", 1'b0, 9'o000, 1'b1, idle_v(3'd3));
        cycle("op4_gz0", 1'b1, 9'b100_101_110, 1'b0, vec(1, 1, 0, 0, 0, 0, 4'd15, 3'd5));
        cycle("op4_gz0_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd5));
`endif

        // Async reset during T2 of add R5,R6: strobes drop at once and T3 never happens.
        cycle("ar_t1", 1'b1, 9'b010_101_110, 1'b0, vec(1, 0, 0, 0, 1, 0, 4'd5, 3'd5));
        cycle("ar_t2", 1'b0, 9'o000, 1'b0, vec(1, 0, 0, 1, 0, 0, 4'd6, 3'd5));
        #1 resetn = 1'b0;
        exp_q.push_back(idle_v(3'd0));
        #1 check_now("ar_async");
        #1 resetn = 1'b1;
        cycle("ar_no_t3", 1'b0, 9'o000, 1'b0, idle_v(3'd0));
        cycle("ar_idle", 1'b0, 9'o000, 1'b0, idle_v(3'd0));

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain: observed %0d left required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
